// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared widths, reset values and defaults for the instruction-ROM arbiter
package rom_arbiter_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W_DEF = 3;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam data_t DATA_RST = '0;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: fetch port, load port and ROM-side signals of the ROM arbiter
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;
  logic if_req;
  addr_t if_addr;
  logic if_flush;
  logic if_gnt;
  logic if_valid;
  data_t if_inst;
  logic ls_req;
  addr_t ls_addr;
  logic ls_gnt;
  logic ls_valid;
  data_t ls_data;
  addr_t rom_addr;
  logic rom_flush;
  data_t rom_inst;
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_addr, rom_inst,
    input if_gnt, if_valid, if_inst, ls_gnt, ls_valid, ls_data, rom_addr, rom_flush
  );
  modport slave (
    input if_req, if_addr, if_flush, ls_req, ls_addr, rom_inst,
    output if_gnt, if_valid, if_inst, ls_gnt, ls_valid, ls_data, rom_addr, rom_flush
  );
endinterface

// File: rtl/rom_starve_cnt.sv
// rom_starve_cnt: saturating count of consecutive denied fetch cycles
module rom_starve_cnt
  import rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic starve
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
  assign starve = cnt >= MAX;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the ROM read port between fetch and load, load first with a fetch starvation guard
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  rom_arbiter_if.slave bus
);
  logic starve, if_valid_q, fetch_wait;
  assign bus.ls_gnt = ~rst & bus.ls_req & ~(starve & bus.if_req & ~bus.if_flush);
  assign bus.if_gnt = ~rst & bus.if_req & ~bus.if_flush & ~bus.ls_gnt;
  assign bus.rom_addr = bus.ls_gnt ? bus.ls_addr : bus.if_addr;
  assign bus.rom_flush = bus.if_flush & ~bus.ls_gnt;
  assign bus.if_valid = if_valid_q & ~bus.if_flush;
  assign fetch_wait = bus.if_req & ~bus.if_gnt & ~bus.if_flush;
  rom_starve_cnt #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(~fetch_wait),
    .inc(fetch_wait),
    .starve(starve)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_valid_q <= 1'b0;
      bus.ls_valid <= 1'b0;
      bus.if_inst <= DATA_RST;
      bus.ls_data <= DATA_RST;
    end else begin
      if_valid_q <= bus.if_gnt;
      bus.ls_valid <= bus.ls_gnt;
      if (bus.if_gnt) bus.if_inst <= bus.rom_inst;
      if (bus.ls_gnt) bus.ls_data <= bus.rom_inst;
    end
endmodule
